// File: rtl/dlx_pkg.sv
// ---------------------------------------------------------------------------
// dlx_pkg -- definitions shared by the DLX pipeline stages.
//   mem_state_e     : memory-stage bus FSM states (IDLE, WAIT)
//   TIMEOUT_DEFAULT : default number of WAIT cycles before a bus abort
//   WCNT_W          : width of the memory-stage wait counter
// ---------------------------------------------------------------------------
package dlx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  localparam int WCNT_W          = 5;

endpackage : dlx_pkg

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-bus connection between the MEM stage and memory.
//   d_addr  [31:0] : byte address            (master -> slave)
//   d_wdata [31:0] : write data              (master -> slave)
//   d_we           : write strobe            (master -> slave)
//   d_req          : access request          (master -> slave)
//   d_ack          : access acknowledge      (slave -> master)
//   d_rdata [31:0] : read data, valid with d_ack (slave -> master)
// ---------------------------------------------------------------------------
interface mem_stage_if;

  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_req;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (
    output d_addr,
    output d_wdata,
    output d_we,
    output d_req,
    input  d_ack,
    input  d_rdata
  );

  modport slave (
    input  d_addr,
    input  d_wdata,
    input  d_we,
    input  d_req,
    output d_ack,
    output d_rdata
  );

endinterface : mem_stage_if

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- DLX memory stage with a request/acknowledge data bus.
// A memory op issues its bus request combinationally; if no acknowledge comes
// in the same cycle the access parks in WAIT with its address/data/we latched
// and the upstream stages are frozen until d_ack or a timeout abort.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   ALU_out_MEM        [31:0] : EX result / byte address of a load or store
//   d_write_enable_MEM        : instruction is a store (wins over a load)
//   d_load_enable_MEM         : instruction is a load
//   Rd_MEM              [4:0] : destination register (0 = no writeback)
//   Rs2_MEM             [4:0] : store-data source register
//   S2_MEM             [31:0] : store-data value read in DE
//   dbus                      : data bus (mem_stage_if.master)
//   stall_MEM                 : freeze request to IF/DE/EX
//   ALU_out_MEM_backward      : forwarding value to EX
//   Rd_MEM_backward     [4:0] : forwarding index to EX (0 for loads)
//   Res_WB/Rd_WB/reg_we_WB    : writeback pipeline register
//   bus_err_WB                : one-cycle pulse after a timeout abort
// ---------------------------------------------------------------------------
module mem_stage
  import dlx_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        ALU_out_MEM,
  input  logic               d_write_enable_MEM,
  input  logic               d_load_enable_MEM,
  input  logic [4:0]         Rd_MEM,
  input  logic [4:0]         Rs2_MEM,
  input  logic [31:0]        S2_MEM,
  mem_stage_if.master        dbus,
  output logic               stall_MEM,
  output logic [31:0]        ALU_out_MEM_backward,
  output logic [4:0]         Rd_MEM_backward,
  output logic [31:0]        Res_WB,
  output logic [4:0]         Rd_WB,
  output logic               reg_we_WB,
  output logic               bus_err_WB
);

  mem_state_e        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;

  logic [31:0]       r_res_wb;
  logic [4:0]        r_rd_wb;
  logic              r_reg_we_wb;
  logic              r_bus_err_wb;

  logic              w_mem_op;
  logic              w_in_wait;
  logic              w_active;
  logic              w_fwd_hit;
  logic [31:0]       w_fwd_data;
  logic              w_timeout;
  logic              w_stall;
  logic              w_op_store;
  logic              w_op_load;

  assign w_mem_op  = d_write_enable_MEM | d_load_enable_MEM;
  assign w_in_wait = (r_state == WAIT);

  // Bus is owned while an access is pending; reset forces everything off,
  // even if the state register still reads WAIT in the reset cycle.
  assign w_active  = ~reset & (w_in_wait | w_mem_op);

  // Store data bypass from the writeback register.
  assign w_fwd_hit  = r_reg_we_wb && (r_rd_wb != 5'd0) && (r_rd_wb == Rs2_MEM);
  assign w_fwd_data = w_fwd_hit ? r_res_wb : S2_MEM;

  assign w_timeout = w_in_wait && !dbus.d_ack &&
                     (r_wcnt == WCNT_W'(TIMEOUT - 1));

  // The abort cycle releases the pipeline even though no ack arrived.
  assign w_stall = w_active & ~dbus.d_ack & ~w_timeout;

  // In WAIT the kind of access comes from the latch: the WB bubbles change
  // the forwarding picture, so the live inputs are not trusted for data/we.
  assign w_op_store = w_in_wait ? r_we : d_write_enable_MEM;
  assign w_op_load  = w_in_wait ? ~r_we
                                : (d_load_enable_MEM & ~d_write_enable_MEM);

  assign dbus.d_req   = w_active;
  assign dbus.d_we    = w_active & w_op_store;
  assign dbus.d_addr  = w_in_wait ? r_addr  : ALU_out_MEM;
  assign dbus.d_wdata = w_in_wait ? r_wdata : w_fwd_data;

  assign stall_MEM            = w_stall;
  assign ALU_out_MEM_backward = ALU_out_MEM;
  // A load's ALU result is an address, never the loaded value.
  assign Rd_MEM_backward      = d_load_enable_MEM ? 5'd0 : Rd_MEM;

  assign Res_WB     = r_res_wb;
  assign Rd_WB      = r_rd_wb;
  assign reg_we_WB  = r_reg_we_wb;
  assign bus_err_WB = r_bus_err_wb;

  // Bus FSM, wait counter and access latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_mem_op && !dbus.d_ack) begin
            r_state <= WAIT;
            r_wcnt  <= '0;
            r_addr  <= ALU_out_MEM;
            r_wdata <= w_fwd_data;
            r_we    <= d_write_enable_MEM;
          end
        end
        WAIT: begin
          if (dbus.d_ack || w_timeout) begin
            r_state <= IDLE;
          end else begin
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Writeback register: result on completion, bubble while stalled,
  // zeroed result plus error pulse on a timeout abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_wb     <= '0;
      r_rd_wb      <= '0;
      r_reg_we_wb  <= 1'b0;
      r_bus_err_wb <= 1'b0;
    end else if (w_timeout) begin
      r_res_wb     <= '0;
      r_rd_wb      <= '0;
      r_reg_we_wb  <= 1'b0;
      r_bus_err_wb <= 1'b1;
    end else if (w_stall) begin
      r_rd_wb      <= '0;
      r_reg_we_wb  <= 1'b0;
      r_bus_err_wb <= 1'b0;
    end else begin
      r_res_wb     <= w_op_load ? dbus.d_rdata : ALU_out_MEM;
      r_rd_wb      <= Rd_MEM;
      r_reg_we_wb  <= ~w_op_store && (Rd_MEM != 5'd0);
      r_bus_err_wb <= 1'b0;
    end
  end

endmodule : mem_stage

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
// Single-cycle cases come from a vector table; multi-cycle accesses (delayed
// ack, forwarded store, timeout, reset during WAIT) are hand sequences.
// Every clock, the expected writeback-register contents are pushed to a
// scoreboard queue and popped/compared just after the next rising edge.
// ---------------------------------------------------------------------------
module tb_mem_stage;
  import dlx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_out_MEM;
  logic        d_write_enable_MEM;
  logic        d_load_enable_MEM;
  logic [4:0]  Rd_MEM;
  logic [4:0]  Rs2_MEM;
  logic [31:0] S2_MEM;
  logic        stall_MEM;
  logic [31:0] ALU_out_MEM_backward;
  logic [4:0]  Rd_MEM_backward;
  logic [31:0] Res_WB;
  logic [4:0]  Rd_WB;
  logic        reg_we_WB;
  logic        bus_err_WB;

  mem_stage_if bus ();

  mem_stage #(.TIMEOUT(16)) dut (
    .clk                  (clk),
    .reset                (reset),
    .ALU_out_MEM          (ALU_out_MEM),
    .d_write_enable_MEM   (d_write_enable_MEM),
    .d_load_enable_MEM    (d_load_enable_MEM),
    .Rd_MEM               (Rd_MEM),
    .Rs2_MEM              (Rs2_MEM),
    .S2_MEM               (S2_MEM),
    .dbus                 (bus),
    .stall_MEM            (stall_MEM),
    .ALU_out_MEM_backward (ALU_out_MEM_backward),
    .Rd_MEM_backward      (Rd_MEM_backward),
    .Res_WB               (Res_WB),
    .Rd_WB                (Rd_WB),
    .reg_we_WB            (reg_we_WB),
    .bus_err_WB           (bus_err_WB)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        we;
    logic        err;
    logic        chk_res;
    logic        chk_rd;
  } wb_t;

  typedef struct {
    logic [31:0] alu;
    logic        st;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [31:0] s2;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_stall;
    logic [4:0]  e_rdbw;
    logic [31:0] e_res;
    logic [4:0]  e_rdwb;
    logic        e_regwe;
  } vec_t;

  wb_t  sb_q[$];
  vec_t vecs[8];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wb(input logic [31:0] res, input logic [4:0] rd, input logic we,
                         input logic err, input logic chk_res, input logic chk_rd);
    wb_t e;
    e.res = res; e.rd = rd; e.we = we; e.err = err;
    e.chk_res = chk_res; e.chk_rd = chk_rd;
    sb_q.push_back(e);
  endtask

  task automatic push_bubble();
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Advance one clock, then compare the writeback register with the scoreboard.
  task automatic tick(input string tag);
    wb_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL sb_underflow %s actual=empty required=entry", tag);
    end else begin
      e = sb_q.pop_front();
      if (e.chk_res) chk({tag, ".Res_WB"}, Res_WB, e.res);
      if (e.chk_rd)  chk({tag, ".Rd_WB"}, 32'(Rd_WB), 32'(e.rd));
      chk({tag, ".reg_we_WB"}, 32'(reg_we_WB), 32'(e.we));
      chk({tag, ".bus_err_WB"}, 32'(bus_err_WB), 32'(e.err));
      $display("txn %-10s res=%08h rd=%0d we=%b err=%b stall=%b", tag, Res_WB, Rd_WB,
               reg_we_WB, bus_err_WB, stall_MEM);
    end
  endtask

  task automatic set_in(input logic [31:0] alu, input logic st, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs2, input logic [31:0] s2,
                        input logic ack, input logic [31:0] rdata);
    ALU_out_MEM        = alu;
    d_write_enable_MEM = st;
    d_load_enable_MEM  = ld;
    Rd_MEM             = rd;
    Rs2_MEM            = rs2;
    S2_MEM             = s2;
    bus.d_ack          = ack;
    bus.d_rdata        = rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   stalls;
    logic aborted;

    //            alu          st  ld  rd  rs2 s2            ack rdata         req we  wdata         stl rdbw res           rdwb we
    vecs[0] = '{32'h0000_0010, 0, 0, 3, 0, 32'h0000_0000, 0, 32'h0,        0, 0, 32'h0,        0, 3, 32'h0000_0010, 3, 1};
    vecs[1] = '{32'h0000_0200, 1, 0, 0, 3, 32'h0000_0055, 1, 32'h0,        1, 1, 32'h0000_0010, 0, 0, 32'h0000_0200, 0, 0};
    vecs[2] = '{32'h0000_0300, 0, 1, 7, 0, 32'h0000_0000, 1, 32'h1234_5678, 1, 0, 32'h0,        0, 0, 32'h1234_5678, 7, 1};
    vecs[3] = '{32'h0000_0400, 1, 1, 9, 7, 32'h0000_0066, 1, 32'h0000_DEAD, 1, 1, 32'h1234_5678, 0, 0, 32'h0000_0400, 9, 0};
    vecs[4] = '{32'h0000_0500, 1, 0, 0, 9, 32'h0000_0077, 1, 32'h0,        1, 1, 32'h0000_0077, 0, 0, 32'h0000_0500, 0, 0};
    vecs[5] = '{32'h0000_0600, 0, 1, 0, 0, 32'h0000_0000, 1, 32'h0000_BEEF, 1, 0, 32'h0,        0, 0, 32'h0000_BEEF, 0, 0};
    vecs[6] = '{32'h0000_0700, 0, 0, 0, 0, 32'h0000_0000, 1, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0000_0700, 0, 0};
    vecs[7] = '{32'h0000_0800, 0, 0, 7, 0, 32'h0000_0000, 0, 32'h0,        0, 0, 32'h0,        0, 7, 32'h0000_0800, 7, 1};

    // Reset with a load pending and no ack: bus and stall must stay gated.
    reset = 1'b1;
    set_in(32'h0000_0F00, 1'b0, 1'b1, 5'd1, 5'd0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst.d_req", 32'(bus.d_req), 32'd0);
      chk("rst.stall", 32'(stall_MEM), 32'd0);
      push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick("reset");
    end
    reset = 1'b0;

    // Single-cycle vectors.
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].alu, vecs[i].st, vecs[i].ld, vecs[i].rd, vecs[i].rs2, vecs[i].s2,
             vecs[i].ack, vecs[i].rdata);
      #1;
      chk($sformatf("v%0d.d_req", i), 32'(bus.d_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d.stall", i), 32'(stall_MEM), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d.alu_bw", i), ALU_out_MEM_backward, vecs[i].alu);
      chk($sformatf("v%0d.rd_bw", i), 32'(Rd_MEM_backward), 32'(vecs[i].e_rdbw));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d.d_we", i), 32'(bus.d_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d.d_addr", i), bus.d_addr, vecs[i].alu);
        chk($sformatf("v%0d.d_wdata", i), bus.d_wdata, vecs[i].e_wdata);
      end
      push_wb(vecs[i].e_res, vecs[i].e_rdwb, vecs[i].e_regwe, 1'b0, 1'b1, 1'b1);
      tick($sformatf("vec%0d", i));
    end

    // Load acknowledged after three stalled cycles.
    set_in(32'h0000_0100, 1'b0, 1'b1, 5'd6, 5'd0, 32'h0, 1'b0, 32'hCAFE_F00D);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("ld3.stall%0d", c), 32'(stall_MEM), 32'd1);
      chk($sformatf("ld3.addr%0d", c), bus.d_addr, 32'h0000_0100);
      chk($sformatf("ld3.req%0d", c), 32'(bus.d_req), 32'd1);
      push_bubble();
      tick("ld3_wait");
    end
    bus.d_ack = 1'b1;
    #1;
    chk("ld3.stall_done", 32'(stall_MEM), 32'd0);
    chk("ld3.addr_done", bus.d_addr, 32'h0000_0100);
    push_wb(32'hCAFE_F00D, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("ld3_done");

    // Store whose data comes from the WB bypass; ack after two cycles.
    set_in(32'h0000_00AA, 1'b0, 1'b0, 5'd5, 5'd0, 32'h0, 1'b0, 32'h0);
    #1;
    push_wb(32'h0000_00AA, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("st_prep");
    set_in(32'h0000_0900, 1'b1, 1'b0, 5'd0, 5'd5, 32'h0000_00BB, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("stf.wdata%0d", c), bus.d_wdata, 32'h0000_00AA);
      chk($sformatf("stf.we%0d", c), 32'(bus.d_we), 32'd1);
      chk($sformatf("stf.stall%0d", c), 32'(stall_MEM), 32'd1);
      push_bubble();
      tick("st_wait");
    end
    bus.d_ack = 1'b1;
    #1;
    chk("stf.wdata_done", bus.d_wdata, 32'h0000_00AA);
    chk("stf.stall_done", 32'(stall_MEM), 32'd0);
    push_wb(32'h0000_0900, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("st_done");

    // Timeout: ack held low; expect the entry cycle plus 15 stalled WAIT cycles.
    set_in(32'h0000_0A00, 1'b0, 1'b1, 5'd4, 5'd0, 32'h0, 1'b0, 32'h0);
    stalls  = 0;
    aborted = 1'b0;
    for (int c = 0; c < 40 && !aborted; c++) begin
      #1;
      if (stall_MEM) begin
        stalls++;
        push_bubble();
        tick("to_wait");
      end else begin
        aborted = 1'b1;
        chk("to.req_abort", 32'(bus.d_req), 32'd1);
        push_wb(32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick("to_abort");
      end
    end
    chk("to.aborted", 32'(aborted), 32'd1);
    chk("to.stall_cycles", 32'(stalls), 32'd16);
    set_in(32'h0000_0011, 1'b0, 1'b0, 5'd2, 5'd0, 32'h0, 1'b0, 32'h0);
    #1;
    chk("to.next_stall", 32'(stall_MEM), 32'd0);
    push_wb(32'h0000_0011, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("to_next");

    // Reset asserted in the middle of a WAIT.
    set_in(32'h0000_0B00, 1'b1, 1'b0, 5'd0, 5'd0, 32'h0000_1234, 1'b0, 32'h0);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk($sformatf("rw.stall%0d", c), 32'(stall_MEM), 32'd1);
      push_bubble();
      tick("rw_wait");
    end
    reset = 1'b1;
    #1;
    chk("rw.req_in_rst", 32'(bus.d_req), 32'd0);
    chk("rw.we_in_rst", 32'(bus.d_we), 32'd0);
    chk("rw.stall_in_rst", 32'(stall_MEM), 32'd0);
    push_wb(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rw_reset");
    reset = 1'b0;
    set_in(32'h0000_0033, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b1, 32'hFFFF_FFFF);
    #1;
    chk("rw.late_ack_req", 32'(bus.d_req), 32'd0);
    chk("rw.late_ack_stall", 32'(stall_MEM), 32'd0);
    push_wb(32'h0000_0033, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("rw_lateack");
    set_in(32'h0000_0C00, 1'b0, 1'b1, 5'd8, 5'd0, 32'h0, 1'b0, 32'h0000_5A5A);
    #1;
    chk("rw.idle_addr", bus.d_addr, 32'h0000_0C00);
    chk("rw.idle_stall", 32'(stall_MEM), 32'd1);
    push_bubble();
    tick("rw_ld_wait");
    bus.d_ack = 1'b1;
    #1;
    push_wb(32'h0000_5A5A, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1);
    tick("rw_ld_done");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_stage
